// File: rtl/fpu_addsub_sequencer.sv
// rtl/fpu_addsub_sequencer.sv - request/launch/watchdog/response sequencer for the half-precision add/sub unit
module fpu_addsub_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_x,
    input  logic [15:0] req_y,
    input  logic        req_sub,
    output logic [15:0] au_x,
    output logic [15:0] au_y,
    output logic        au_addSub,
    output logic        au_reset,
    input  logic        au_done,
    input  logic [1:0]  au_ofuf,
    input  logic [15:0] au_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [1:0]  rsp_flags,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_RESP = 2'b11;

    // Last RUN count value before the watchdog aborts the operation.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_au_x;
    logic [15:0] r_au_y;
    logic        r_au_addsub;
    logic        r_au_reset;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_result;
    logic [1:0]  r_rsp_flags;

    // Sequencer: accept, one-cycle load pulse, watch for completion, hold the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_au_x       <= 16'h0000;
            r_au_y       <= 16'h0000;
            r_au_addsub  <= 1'b0;
            r_au_reset   <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 16'h0000;
            r_rsp_flags  <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_au_x      <= req_x;
                        r_au_y      <= req_y;
                        r_au_addsub <= req_sub;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_au_reset <= 1'b0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    // Overflow/underflow wins over done; the unit result is not trusted then.
                    if (au_ofuf != 2'b00) begin
                        r_rsp_flags  <= au_ofuf;
                        r_rsp_result <= 16'h0000;
                        r_rsp_valid  <= 1'b1;
                        r_au_reset   <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (au_done) begin
                        r_rsp_flags  <= 2'b00;
                        r_rsp_result <= au_result;
                        r_rsp_valid  <= 1'b1;
                        r_au_reset   <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_rsp_flags  <= 2'b11;
                        r_rsp_result <= 16'h0000;
                        r_rsp_valid  <= 1'b1;
                        r_au_reset   <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Watchdog: cleared while loading, counts RUN cycles, saturates at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'd0;
        end else if (r_state == ST_LOAD) begin
            r_cnt <= 8'd0;
        end else if ((r_state == ST_RUN) && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign au_x       = r_au_x;
    assign au_y       = r_au_y;
    assign au_addSub  = r_au_addsub;
    assign au_reset   = r_au_reset;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// tb/tb_fpu_addsub_sequencer.sv - self-checking bench for fpu_addsub_sequencer with a stub add/sub unit
module tb_fpu_addsub_sequencer;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic        req_sub;
    logic [15:0] au_x;
    logic [15:0] au_y;
    logic        au_addSub;
    logic        au_reset;
    logic        au_done;
    logic [1:0]  au_ofuf;
    logic [15:0] au_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_flags;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_addsub_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_sub    (req_sub),
        .au_x       (au_x),
        .au_y       (au_y),
        .au_addSub  (au_addSub),
        .au_reset   (au_reset),
        .au_done    (au_done),
        .au_ofuf    (au_ofuf),
        .au_result  (au_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Vector table: operands, and how the stub unit behaves for them.
    logic [15:0] tv_x    [6];
    logic [15:0] tv_y    [6];
    logic        tv_sub  [6];
    int          tv_lat  [6];
    logic        tv_done [6];
    logic [1:0]  tv_ofuf [6];
    logic [15:0] tv_res  [6];
    int          v_idx;

    initial begin
        tv_x[0] = 16'h3C00; tv_y[0] = 16'h3C00; tv_sub[0] = 1'b0; tv_lat[0] = 3; tv_done[0] = 1'b1; tv_ofuf[0] = 2'b00; tv_res[0] = 16'h4000;
        tv_x[1] = 16'h0000; tv_y[1] = 16'h4200; tv_sub[1] = 1'b1; tv_lat[1] = 2; tv_done[1] = 1'b1; tv_ofuf[1] = 2'b00; tv_res[1] = 16'hC200;
        tv_x[2] = 16'h4000; tv_y[2] = 16'h3C00; tv_sub[2] = 1'b1; tv_lat[2] = 4; tv_done[2] = 1'b1; tv_ofuf[2] = 2'b00; tv_res[2] = 16'h3C00;
        tv_x[3] = 16'h7BFF; tv_y[3] = 16'h7BFF; tv_sub[3] = 1'b0; tv_lat[3] = 3; tv_done[3] = 1'b0; tv_ofuf[3] = 2'b10; tv_res[3] = 16'h7C00;
        tv_x[4] = 16'h0400; tv_y[4] = 16'h03FF; tv_sub[4] = 1'b1; tv_lat[4] = 2; tv_done[4] = 1'b1; tv_ofuf[4] = 2'b01; tv_res[4] = 16'h0001;
        tv_x[5] = 16'h1234; tv_y[5] = 16'h5678; tv_sub[5] = 1'b0; tv_lat[5] = 0; tv_done[5] = 1'b0; tv_ofuf[5] = 2'b00; tv_res[5] = 16'hBEEF;
    end

    // Stub unit: counts cycles out of reset, flags/done appear after tv_lat cycles.
    int unsigned stub_cnt;
    logic        stub_hit;
    always @(posedge clk or posedge au_reset) begin
        if (au_reset) stub_cnt <= 0;
        else if (stub_cnt < 255) stub_cnt <= stub_cnt + 1;
    end
    assign stub_hit  = !au_reset && (int'(stub_cnt) >= tv_lat[v_idx]);
    assign au_done   = stub_hit && tv_done[v_idx];
    assign au_ofuf   = stub_hit ? tv_ofuf[v_idx] : 2'b00;
    assign au_result = (stub_hit && tv_done[v_idx]) ? tv_res[v_idx] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding operation with an absolute timeline.
    int unsigned cyc = 0;
    logic        m_active = 1'b0;
    int          m_acc = 0;
    int          m_lat = 0;
    logic [15:0] m_res = 16'h0000;
    logic [1:0]  m_flg = 2'b00;
    logic [15:0] m_x = 16'h0000;
    logic [15:0] m_y = 16'h0000;
    logic        m_sub = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_x      <= 16'h0000;
            m_y      <= 16'h0000;
            m_sub    <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (!m_active && req_valid) begin
                m_active <= 1'b1;
                m_acc    <= int'(cyc);
                m_x      <= req_x;
                m_y      <= req_y;
                m_sub    <= req_sub;
                if (tv_ofuf[v_idx] != 2'b00 && tv_lat[v_idx] + 1 <= TB_TIMEOUT) begin
                    m_flg <= tv_ofuf[v_idx]; m_res <= 16'h0000; m_lat <= tv_lat[v_idx] + 2;
                end else if (tv_done[v_idx] && tv_lat[v_idx] + 1 <= TB_TIMEOUT) begin
                    m_flg <= 2'b00; m_res <= tv_res[v_idx]; m_lat <= tv_lat[v_idx] + 2;
                end else begin
                    m_flg <= 2'b11; m_res <= 16'h0000; m_lat <= TB_TIMEOUT + 1;
                end
            end else if (m_active && int'(cyc) >= m_acc + m_lat + 1 && rsp_ready) begin
                m_active <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    int cmp_p;
    always @(negedge clk) begin
        #2;
        if (!m_active) begin
            chk("idle req_ready", req_ready, 1);
            chk("idle busy", busy, 0);
            chk("idle au_reset", au_reset, 1);
            chk("idle rsp_valid", rsp_valid, 0);
            if (!reset) begin
                chk("rst rsp_result", rsp_result, 0);
                chk("rst rsp_flags", rsp_flags, 0);
            end
        end else begin
            cmp_p = int'(cyc) - 1 - m_acc;
            chk("act req_ready", req_ready, 0);
            chk("act busy", busy, 1);
            chk("act au_reset", au_reset, (cmp_p == 0 || cmp_p >= m_lat) ? 1 : 0);
            chk("act rsp_valid", rsp_valid, (cmp_p >= m_lat) ? 1 : 0);
            if (cmp_p >= m_lat) begin
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_flags", rsp_flags, m_flg);
            end
        end
        chk("au_x", au_x, m_x);
        chk("au_y", au_y, m_y);
        chk("au_addSub", au_addSub, m_sub);
    end

    task automatic wait_rsp(output int edges);
        int n;
        bit got;
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
            #1;
            if (rsp_valid) got = 1;
        end
        edges = got ? n - 1 : 999;
    endtask

    task automatic do_op(input int idx, input logic [15:0] er, input logic [1:0] ef, input int el);
        int edges;
        @(negedge clk);
        v_idx     = idx;
        req_x     = tv_x[idx];
        req_y     = tv_y[idx];
        req_sub   = tv_sub[idx];
        req_valid = 1'b1;
        wait_rsp(edges);
        chk($sformatf("latency v%0d", idx), edges, el);
        chk($sformatf("result v%0d", idx), rsp_result, er);
        chk($sformatf("flags v%0d", idx), rsp_flags, ef);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, req_ready, 1);
        chk({tag, " au_reset"}, au_reset, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " au_x"}, au_x, 0);
        chk({tag, " au_y"}, au_y, 0);
        chk({tag, " au_addSub"}, au_addSub, 0);
        chk({tag, " rsp_valid"}, rsp_valid, 0);
        chk({tag, " rsp_result"}, rsp_result, 0);
        chk({tag, " rsp_flags"}, rsp_flags, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int edges;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_x     = 16'h0000;
        req_y     = 16'h0000;
        req_sub   = 1'b0;
        rsp_ready = 1'b1;
        v_idx     = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        do_op(0, 16'h4000, 2'b00, 5);
        do_op(1, 16'hC200, 2'b00, 4);
        do_op(2, 16'h3C00, 2'b00, 6);
        do_op(3, 16'h0000, 2'b10, 5);
        do_op(4, 16'h0000, 2'b01, 4);
        do_op(5, 16'h0000, 2'b11, 9);

        // Backpressure with a second request held pending.
        @(negedge clk);
        v_idx = 0; req_x = tv_x[0]; req_y = tv_y[0]; req_sub = tv_sub[0];
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp rsp_valid", rsp_valid, 1);
            chk("bp rsp_result", rsp_result, 16'h4000);
            chk("bp rsp_flags", rsp_flags, 2'b00);
            chk("bp req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp after hs req_ready", req_ready, 1);
        chk("bp after hs rsp_valid", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("bp pending accepted busy", busy, 1);
        chk("bp pending accepted req_ready", req_ready, 0);
        wait_rsp(edges);
        chk("bp second latency", edges, 4);
        chk("bp second result", rsp_result, 16'h4000);

        // Reset pulse in the middle of RUN.
        @(negedge clk);
        v_idx = 2; req_x = tv_x[2]; req_y = tv_y[2]; req_sub = tv_sub[2];
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrun");
        @(negedge clk);
        reset = 1'b1;
        do_op(0, 16'h4000, 2'b00, 5);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_sequencer.md
# fpu_addsub_sequencer

Front-end controller that sits directly upstream of the 16-bit half-precision add/sub unit. It accepts operation requests over a valid/ready handshake and registers the operands. It launches the unit by pulsing the unit's active-high load/reset input, then detects completion, overflow, underflow or a hang. It returns a registered result and status word over a second valid/ready handshake to the downstream consumer.

## Interface
Parameters:
- TIMEOUT, default 64: maximum number of RUN cycles allowed before the operation is aborted with timeout status. Legal range is 2..255.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset. When low, the block returns to its reset state immediately.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_x  in  16  operand X (IEEE half).
- req_y  in  16  operand Y (IEEE half).
- req_sub  in  1  0 = add, 1 = subtract.
- au_x  out  16  registered operand X to the unit.
- au_y  out  16  registered operand Y to the unit.
- au_addSub  out  1  registered operation select to the unit.
- au_reset  out  1  registered, active-high load/reset to the unit.
- au_done  in  1  unit done flag.
- au_ofuf  in  2  unit overflow/underflow code.
- au_result  in  16  unit result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  16  registered result.
- rsp_flags  out  2  00 = ok, 10 = overflow, 01 = underflow, 11 = timeout.
- busy  out  1  high in LOAD, RUN and RESP.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - req_ready = 1 and au_reset = 1, so the unit is parked.
  - On req_valid & req_ready, capture req_x, req_y and req_sub into au_x, au_y and au_addSub, then go to LOAD.
- LOAD:
  - Exactly one cycle with au_reset = 1 and the operands stable, so the unit samples them.
  - Clear the watchdog counter and go to RUN.
- RUN:
  - au_reset = 0 and the watchdog counter increments each cycle.
  - Completion is checked in priority order:
    - au_ofuf != 00: rsp_flags = au_ofuf, rsp_result = 16'h0000 (the unit's result is not trusted here). This also covers exponent overflow, where the unit never raises au_done.
    - Otherwise au_done = 1: rsp_flags = 00, rsp_result = au_result.
    - Otherwise the counter reaches TIMEOUT-1: rsp_flags = 11, rsp_result = 16'h0000.
  - Any completion sets rsp_valid = 1 and goes to RESP.
- RESP:
  - au_reset = 1.
  - rsp_valid, rsp_result and rsp_flags are held stable until rsp_valid & rsp_ready.
  - On that handshake, clear rsp_valid and go to IDLE.
- Watchdog counter width is 8 bits. It saturates and never wraps.
- Requests arriving while busy are not accepted: req_ready stays 0 and the requester must hold its request.

## Timing
- Reset values:
  - State IDLE.
  - req_ready 1, au_reset 1, busy 0.
  - au_x and au_y 16'h0000, au_addSub 0.
  - rsp_valid 0, rsp_result 16'h0000, rsp_flags 00, counter 0.
- Accept edge E0 (IDLE→LOAD), E1 (LOAD→RUN).
  - The unit runs from E1 onward.
  - If au_done is first seen high in the cycle before edge En, rsp_valid is high after En.
- Response latency is unit latency + 2 cycles from the accept edge.
- rsp_ready held high → RESP lasts 1 cycle; the next request can be accepted 1 cycle after the response handshake.
- au_reset is a flop output, so it is glitch-free. The unit is reset asynchronously from it.
- Reset asserted mid-operation (any state):
  - All outputs return to their reset values immediately.
  - A pending response is discarded.
  - au_reset goes high, so the unit is also reset.
- Simultaneous au_done and au_ofuf != 00 (underflow case): the flags take priority and the result is 0000.
- The timeout fires on the RUN cycle where the counter equals TIMEOUT-1, giving a total of TIMEOUT cycles in RUN.

## Test plan
- 1.0 + 1.0: req_x = 3C00, req_y = 3C00, req_sub = 0 → rsp_result = 4000, rsp_flags = 00. Latency matches unit latency + 2.
- Subtract with zero X: X = 0000, Y = 4200, req_sub = 1 → rsp_result = C200, rsp_flags = 00. Also 4000 − 3C00 → 3C00, flags 00.
- Overflow: 7BFF + 7BFF → rsp_flags = 10, rsp_result = 0000. The response must arrive even though au_done never rises.
- Timeout: TIMEOUT = 8 with a stub unit that never completes → rsp_flags = 11, rsp_result = 0000, after exactly 8 RUN cycles.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid rises → rsp_valid, rsp_result and rsp_flags stay stable, req_ready = 0, and a pending req_valid is not accepted until 1 cycle after the response handshake.
- Reset = 0 for 1 cycle mid-RUN → all outputs return to their reset values at once. The next request 3C00 + 3C00 then completes normally with 4000.
